// File: rtl/array_cursor_pkg.sv
// rtl/array_cursor_pkg.sv - shared types and cursor step helpers for array_cursor_reader
//
// Purpose : command encoding and the pure cursor-update arithmetic used by
//           the top level and, when ARRAY_CURSOR_BOUNDS_CHECK_EN is defined,
//           the bound-crossing detector.
// Ports   : none (package).
package array_cursor_pkg;

  typedef enum logic [2:0] {
    NOP      = 3'd0,
    READ     = 3'd1,
    PRE_INC  = 3'd2,
    POST_INC = 3'd3,
    PRE_DEC  = 3'd4,
    POST_DEC = 3'd5,
    SET      = 3'd6
  } op_e;

  // Arithmetic is done 32 bits wide so that +1 on the last index and -1 on
  // zero never alias before the bound test; callers truncate to the cursor width.
  function automatic logic [31:0] cursor_next(input logic [31:0] pos, input op_e op,
                                              input logic wrap, input logic [31:0] depth);
    logic [31:0] nxt;
    nxt = pos;
    case (op)
      PRE_INC, POST_INC: begin
        if (pos == depth - 32'd1) nxt = wrap ? 32'd0 : pos;
        else                      nxt = pos + 32'd1;
      end
      PRE_DEC, POST_DEC: begin
        if (pos == 32'd0) nxt = wrap ? depth - 32'd1 : pos;
        else              nxt = pos - 32'd1;
      end
      default: nxt = pos;
    endcase
    return nxt;
  endfunction

  // True when an INC/DEC step would leave [0, depth-1], whether or not it wraps.
  function automatic logic crosses_bound(input logic [31:0] pos, input op_e op,
                                         input logic [31:0] depth);
    return ((op == PRE_INC || op == POST_INC) && pos == depth - 32'd1) ||
           ((op == PRE_DEC || op == POST_DEC) && pos == 32'd0);
  endfunction

endpackage

// File: rtl/array_cursor_reader_if.sv
// rtl/array_cursor_reader_if.sv - request/write/response bundle for array_cursor_reader
//
// Purpose : groups the command handshake, the array write port and the
//           response handshake.
// Ports   : master drives req_*, wr_*, rd_ready; slave (the array) drives
//           req_ready, rd_valid, rd_data, rd_pos, rd_i0/i1/i2.
interface array_cursor_reader_if #(
  parameter int W  = 32,
  parameter int D0 = 2,
  parameter int D1 = 3,
  parameter int D2 = 4
);
  localparam int DEPTH = D0 * D1 * D2;
  localparam int PW    = $clog2(DEPTH);

  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [PW-1:0]         req_pos;
  logic                  req_guard;
  logic                  wr_en;
  logic [PW-1:0]         wr_addr;
  logic [W-1:0]          wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [W-1:0]          rd_data;
  logic [PW-1:0]         rd_pos;
  logic [$clog2(D0)-1:0] rd_i0;
  logic [$clog2(D1)-1:0] rd_i1;
  logic [$clog2(D2)-1:0] rd_i2;

  modport master (
    output req_valid, req_op, req_pos, req_guard, wr_en, wr_addr, wr_data, rd_ready,
    input  req_ready, rd_valid, rd_data, rd_pos, rd_i0, rd_i1, rd_i2
  );

  modport slave (
    input  req_valid, req_op, req_pos, req_guard, wr_en, wr_addr, wr_data, rd_ready,
    output req_ready, rd_valid, rd_data, rd_pos, rd_i0, rd_i1, rd_i2
  );

endinterface

// File: rtl/array_cursor_coord.sv
// rtl/array_cursor_coord.sv - linear index to (i0,i1,i2) decoder
//
// Purpose : splits a row-major linear index of a D0 x D1 x D2 array into its
//           three coordinates. Purely combinational.
// Ports   : pos (in, linear index), i0/i1/i2 (out, outer/middle/inner coordinate).
module array_cursor_coord #(
  parameter  int D0  = 2,
  parameter  int D1  = 3,
  parameter  int D2  = 4,
  localparam int PW  = $clog2(D0 * D1 * D2),
  localparam int I0W = $clog2(D0),
  localparam int I1W = $clog2(D1),
  localparam int I2W = $clog2(D2)
) (
  input  logic [PW-1:0]  pos,
  output logic [I0W-1:0] i0,
  output logic [I1W-1:0] i1,
  output logic [I2W-1:0] i2
);

  logic [31:0] pos_w;
  assign pos_w = 32'(pos);

  assign i0 = I0W'(pos_w / 32'(D1 * D2));
  assign i1 = I1W'((pos_w / 32'(D2)) % 32'(D1));
  assign i2 = I2W'(pos_w % 32'(D2));

endmodule

// File: rtl/array_cursor_reader.sv
// rtl/array_cursor_reader.sv - D0 x D1 x D2 word array read through a side-effecting cursor
//
// Purpose : accepts cursor commands (READ, PRE/POST INC/DEC, SET) and returns
//           the addressed word, the updated cursor and its 3-D coordinates
//           through a single-entry response register. A free-running write
//           port updates the array with read-before-write semantics.
// Ports   : clk, rst (sync, active-high); bus (array_cursor_reader_if.slave);
//           err_oob (out, sticky out-of-bounds flag) only when
//           ARRAY_CURSOR_BOUNDS_CHECK_EN is defined.
// Params  : W, D0, D1, D2, WRAP (1 wrap / 0 saturate),
//           GUARD_MODE (0 guard suppresses cursor change / 1 cursor always moves).
module array_cursor_reader
  import array_cursor_pkg::*;
#(
  parameter int W          = 32,
  parameter int D0         = 2,
  parameter int D1         = 3,
  parameter int D2         = 4,
  parameter int WRAP       = 1,
  parameter int GUARD_MODE = 0
) (
  input logic clk,
  input logic rst,
  array_cursor_reader_if.slave bus
`ifdef ARRAY_CURSOR_BOUNDS_CHECK_EN
  ,
  output logic err_oob
`endif
);

  localparam int            DEPTH   = D0 * D1 * D2;
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_X = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] cursor;
  logic [PW-1:0] step_pos;
  logic [PW-1:0] set_pos;
  logic [PW-1:0] cur_upd;
  logic [PW-1:0] commit_pos;
  logic [PW-1:0] acc_addr;
  logic [PW-1:0] rd_pos_q;
  logic [W-1:0]  rd_data_q;
  logic [W-1:0]  mem [DEPTH];
  logic          accept;
  logic          is_nop;
  logic          guard_off;
  logic          set_oob;
  logic          wr_oob;

  assign bus.req_ready = (state == IDLE) || bus.rd_ready;
  assign accept        = bus.req_valid && bus.req_ready;
  assign guard_off     = !bus.req_guard;

  assign step_pos = PW'(cursor_next(32'(cursor), op_e'(bus.req_op), WRAP != 0, 32'(DEPTH)));
  assign set_oob  = {1'b0, bus.req_pos} >= DEPTH_X;
  assign set_pos  = set_oob ? LAST : bus.req_pos;
  assign wr_oob   = {1'b0, bus.wr_addr} >= DEPTH_X;

  // PRE_* and SET read at the new cursor, READ and POST_* at the old one.
  always_comb begin
    cur_upd  = cursor;
    acc_addr = cursor;
    is_nop   = 1'b0;
    case (bus.req_op)
      READ:               acc_addr = cursor;
      PRE_INC, PRE_DEC: begin
        cur_upd  = step_pos;
        acc_addr = step_pos;
      end
      POST_INC, POST_DEC: cur_upd = step_pos;
      SET: begin
        cur_upd  = set_pos;
        acc_addr = set_pos;
      end
      default:            is_nop = 1'b1;
    endcase
  end

  // In logical guard mode a low guard also cancels the cursor side effect.
  assign commit_pos = (guard_off && GUARD_MODE == 0) ? cursor : cur_upd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cursor    <= '0;
      rd_pos_q  <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= W'(i);
    end else begin
      if (bus.wr_en && !wr_oob) mem[bus.wr_addr] <= bus.wr_data;
      if (accept && !is_nop) begin
        state     <= HOLD;
        cursor    <= commit_pos;
        rd_pos_q  <= commit_pos;
        rd_data_q <= guard_off ? '0 : mem[acc_addr];
      end else if (bus.rd_ready) begin
        state <= IDLE;
      end
    end
  end

  assign bus.rd_valid = (state == HOLD);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_pos   = rd_pos_q;

  array_cursor_coord #(.D0(D0), .D1(D1), .D2(D2)) u_coord (
    .pos (rd_pos_q),
    .i0  (bus.rd_i0),
    .i1  (bus.rd_i1),
    .i2  (bus.rd_i2)
  );

`ifdef ARRAY_CURSOR_BOUNDS_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((accept && (crosses_bound(32'(cursor), op_e'(bus.req_op), 32'(DEPTH)) ||
                             (bus.req_op == SET && set_oob))) ||
                 (bus.wr_en && wr_oob)) begin
      err_q <= 1'b1;
    end
  end
  assign err_oob = err_q;
`else
  logic unused_oob;
  assign unused_oob = set_oob;
`endif

endmodule

// File: tb/tb_array_cursor_reader.sv
// tb/tb_array_cursor_reader.sv - directed self-checking bench for array_cursor_reader
//
// dut0: WRAP=1, GUARD_MODE=0. dut1: WRAP=0, GUARD_MODE=1.
// err_oob checks are built when ARRAY_CURSOR_BOUNDS_CHECK_EN is defined.
module tb_array_cursor_reader;

  localparam logic [2:0] OP_NOP = 3'd0, OP_READ = 3'd1, OP_PRE_INC = 3'd2, OP_POST_INC = 3'd3;
  localparam logic [2:0] OP_PRE_DEC = 3'd4, OP_POST_DEC = 3'd5, OP_SET = 3'd6, OP_RSVD = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  array_cursor_reader_if #(.W(32), .D0(2), .D1(3), .D2(4)) if0 ();
  array_cursor_reader_if #(.W(32), .D0(2), .D1(3), .D2(4)) if1 ();

`ifdef ARRAY_CURSOR_BOUNDS_CHECK_EN
  logic err0, err1;
`endif

  array_cursor_reader #(.W(32), .D0(2), .D1(3), .D2(4), .WRAP(1), .GUARD_MODE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
`ifdef ARRAY_CURSOR_BOUNDS_CHECK_EN
    ,
    .err_oob (err0)
`endif
  );

  array_cursor_reader #(.W(32), .D0(2), .D1(3), .D2(4), .WRAP(0), .GUARD_MODE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
`ifdef ARRAY_CURSOR_BOUNDS_CHECK_EN
    ,
    .err_oob (err1)
`endif
  );

  task automatic send0(input logic [2:0] op, input logic [4:0] pos, input logic guard);
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_op = op; if0.req_pos = pos; if0.req_guard = guard;
    if0.rd_ready = 1'b1;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
  endtask

  task automatic send1(input logic [2:0] op, input logic [4:0] pos, input logic guard);
    @(negedge clk);
    if1.req_valid = 1'b1; if1.req_op = op; if1.req_pos = pos; if1.req_guard = guard;
    if1.rd_ready = 1'b1;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    total++; if (if0.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", if0.rd_valid); end
    total++; if (if0.rd_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", if0.rd_data); end
    total++; if (if0.rd_pos !== 5'd0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", if0.rd_pos); end
    total++; if ({if0.rd_i0, if0.rd_i1, if0.rd_i2} !== 5'd0) begin bad++; $display("FAIL reset_coord got=%0d/%0d/%0d exp=0/0/0", if0.rd_i0, if0.rd_i1, if0.rd_i2); end
    total++; if (if0.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h exp=1", if0.req_ready); end
`ifdef ARRAY_CURSOR_BOUNDS_CHECK_EN
    total++; if (err0 !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h exp=0", err0); end
`endif
  endtask

  task automatic test_inc_dec;
    send0(OP_PRE_INC, 5'd0, 1'b1);
    total++; if (if0.rd_valid !== 1'b1) begin bad++; $display("FAIL preinc_valid got=%0h exp=1", if0.rd_valid); end
    total++; if (if0.rd_data !== 32'd1 || if0.rd_pos !== 5'd1) begin bad++; $display("FAIL preinc got=%0h/%0d exp=1/1", if0.rd_data, if0.rd_pos); end
    send0(OP_POST_INC, 5'd0, 1'b1);
    total++; if (if0.rd_data !== 32'd1 || if0.rd_pos !== 5'd2) begin bad++; $display("FAIL postinc got=%0h/%0d exp=1/2", if0.rd_data, if0.rd_pos); end
    send0(OP_POST_DEC, 5'd0, 1'b1);
    total++; if (if0.rd_data !== 32'd2 || if0.rd_pos !== 5'd1) begin bad++; $display("FAIL postdec got=%0h/%0d exp=2/1", if0.rd_data, if0.rd_pos); end
  endtask

  task automatic test_set_coord;
    send0(OP_SET, 5'd23, 1'b1);
    total++; if (if0.rd_data !== 32'd23 || if0.rd_pos !== 5'd23) begin bad++; $display("FAIL set23 got=%0h/%0d exp=17/23", if0.rd_data, if0.rd_pos); end
    total++; if (if0.rd_i0 !== 1'd1 || if0.rd_i1 !== 2'd2 || if0.rd_i2 !== 2'd3) begin bad++; $display("FAIL coord23 got=%0d/%0d/%0d exp=1/2/3", if0.rd_i0, if0.rd_i1, if0.rd_i2); end
    send0(OP_POST_INC, 5'd0, 1'b1);
    total++; if (if0.rd_data !== 32'd23 || if0.rd_pos !== 5'd0) begin bad++; $display("FAIL wrap_inc got=%0h/%0d exp=17/0", if0.rd_data, if0.rd_pos); end
    total++; if ({if0.rd_i0, if0.rd_i1, if0.rd_i2} !== 5'd0) begin bad++; $display("FAIL coord0 got=%0d/%0d/%0d exp=0/0/0", if0.rd_i0, if0.rd_i1, if0.rd_i2); end
`ifdef ARRAY_CURSOR_BOUNDS_CHECK_EN
    total++; if (err0 !== 1'b1) begin bad++; $display("FAIL wrap_err got=%0h exp=1", err0); end
`endif
  endtask

  task automatic test_wrap_dec_clamp;
    send0(OP_PRE_DEC, 5'd0, 1'b1);
    total++; if (if0.rd_data !== 32'd23 || if0.rd_pos !== 5'd23) begin bad++; $display("FAIL wrap_dec got=%0h/%0d exp=17/23", if0.rd_data, if0.rd_pos); end
    send0(OP_SET, 5'd0, 1'b1);
    send0(OP_SET, 5'd30, 1'b1);
    total++; if (if0.rd_data !== 32'd23 || if0.rd_pos !== 5'd23) begin bad++; $display("FAIL set_clamp got=%0h/%0d exp=17/23", if0.rd_data, if0.rd_pos); end
    send0(OP_SET, 5'd9, 1'b1);
    total++; if (if0.rd_i0 !== 1'd0 || if0.rd_i1 !== 2'd2 || if0.rd_i2 !== 2'd1) begin bad++; $display("FAIL coord9 got=%0d/%0d/%0d exp=0/2/1", if0.rd_i0, if0.rd_i1, if0.rd_i2); end
  endtask

  task automatic test_guard_logical;
    send0(OP_SET, 5'd4, 1'b1);
    send0(OP_PRE_INC, 5'd0, 1'b0);
    total++; if (if0.rd_data !== 32'd0 || if0.rd_pos !== 5'd4) begin bad++; $display("FAIL guard0 got=%0h/%0d exp=0/4", if0.rd_data, if0.rd_pos); end
    send0(OP_READ, 5'd0, 1'b1);
    total++; if (if0.rd_data !== 32'd4 || if0.rd_pos !== 5'd4) begin bad++; $display("FAIL guard0_after got=%0h/%0d exp=4/4", if0.rd_data, if0.rd_pos); end
  endtask

  task automatic test_write_rbw;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_op = OP_SET; if0.req_pos = 5'd5; if0.req_guard = 1'b1;
    if0.wr_en = 1'b1; if0.wr_addr = 5'd5; if0.wr_data = 32'hAA; if0.rd_ready = 1'b1;
    @(posedge clk); #1;
    if0.req_valid = 1'b0; if0.wr_en = 1'b0;
    total++; if (if0.rd_data !== 32'd5 || if0.rd_pos !== 5'd5) begin bad++; $display("FAIL rbw_old got=%0h/%0d exp=5/5", if0.rd_data, if0.rd_pos); end
    send0(OP_READ, 5'd0, 1'b1);
    total++; if (if0.rd_data !== 32'hAA) begin bad++; $display("FAIL rbw_new got=%0h exp=aa", if0.rd_data); end
  endtask

  task automatic test_nop;
    send0(OP_NOP, 5'd0, 1'b1);
    total++; if (if0.rd_valid !== 1'b0) begin bad++; $display("FAIL nop_valid got=%0h exp=0", if0.rd_valid); end
    send0(OP_RSVD, 5'd0, 1'b1);
    total++; if (if0.rd_valid !== 1'b0) begin bad++; $display("FAIL op7_valid got=%0h exp=0", if0.rd_valid); end
    send0(OP_READ, 5'd0, 1'b1);
    total++; if (if0.rd_data !== 32'hAA || if0.rd_pos !== 5'd5) begin bad++; $display("FAIL nop_cursor got=%0h/%0d exp=aa/5", if0.rd_data, if0.rd_pos); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_op = OP_PRE_INC; if0.req_guard = 1'b1; if0.rd_ready = 1'b1;
    for (int k = 6; k <= 8; k++) begin
      @(posedge clk); #1;
      total++; if (if0.rd_valid !== 1'b1 || if0.rd_data !== 32'(k) || if0.rd_pos !== 5'(k)) begin
        bad++; $display("FAIL b2b_%0d got=%0h/%0h/%0d exp=1/%0h/%0d", k, if0.rd_valid, if0.rd_data, if0.rd_pos, k, k);
      end
    end
    @(negedge clk); if0.req_valid = 1'b0;
  endtask

  task automatic test_hold;
    @(posedge clk); #1;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_op = OP_READ; if0.req_guard = 1'b1; if0.rd_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (if0.rd_valid !== 1'b1 || if0.rd_data !== 32'd8) begin bad++; $display("FAIL hold_first got=%0h/%0h exp=1/8", if0.rd_valid, if0.rd_data); end
    @(negedge clk); if0.req_op = OP_PRE_INC;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (if0.req_ready !== 1'b0 || if0.rd_valid !== 1'b1 || if0.rd_data !== 32'd8 || if0.rd_pos !== 5'd8) begin
        bad++; $display("FAIL hold_stall_%0d got=%0h/%0h/%0h/%0d exp=0/1/8/8", k, if0.req_ready, if0.rd_valid, if0.rd_data, if0.rd_pos);
      end
    end
    @(negedge clk); if0.rd_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (if0.rd_valid !== 1'b1 || if0.rd_data !== 32'd9 || if0.rd_pos !== 5'd9) begin bad++; $display("FAIL hold_release got=%0h/%0h/%0d exp=1/9/9", if0.rd_valid, if0.rd_data, if0.rd_pos); end
    @(negedge clk); if0.req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (if0.rd_valid !== 1'b0) begin bad++; $display("FAIL hold_drain got=%0h exp=0", if0.rd_valid); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_op = OP_READ; if0.req_guard = 1'b1; if0.rd_ready = 1'b0;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (if0.rd_valid !== 1'b0 || if0.rd_pos !== 5'd0) begin bad++; $display("FAIL midrst got=%0h/%0d exp=0/0", if0.rd_valid, if0.rd_pos); end
    @(negedge clk); rst = 1'b0; if0.rd_ready = 1'b1;
    send0(OP_SET, 5'd5, 1'b1);
    total++; if (if0.rd_data !== 32'd5) begin bad++; $display("FAIL midrst_mem got=%0h exp=5", if0.rd_data); end
  endtask

  task automatic test_saturate;
`ifdef ARRAY_CURSOR_BOUNDS_CHECK_EN
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL sat_err_init got=%0h exp=0", err1); end
`endif
    send1(OP_SET, 5'd23, 1'b1);
    send1(OP_POST_INC, 5'd0, 1'b1);
    total++; if (if1.rd_data !== 32'd23 || if1.rd_pos !== 5'd23) begin bad++; $display("FAIL sat_inc got=%0h/%0d exp=17/23", if1.rd_data, if1.rd_pos); end
`ifdef ARRAY_CURSOR_BOUNDS_CHECK_EN
    total++; if (err1 !== 1'b1) begin bad++; $display("FAIL sat_err got=%0h exp=1", err1); end
`endif
    send1(OP_SET, 5'd0, 1'b1);
    send1(OP_PRE_DEC, 5'd0, 1'b1);
    total++; if (if1.rd_data !== 32'd0 || if1.rd_pos !== 5'd0) begin bad++; $display("FAIL sat_dec got=%0h/%0d exp=0/0", if1.rd_data, if1.rd_pos); end
  endtask

  task automatic test_guard_bitwise;
    send1(OP_PRE_INC, 5'd0, 1'b0);
    total++; if (if1.rd_data !== 32'd0 || if1.rd_pos !== 5'd1) begin bad++; $display("FAIL guard1 got=%0h/%0d exp=0/1", if1.rd_data, if1.rd_pos); end
    send1(OP_READ, 5'd0, 1'b1);
    total++; if (if1.rd_data !== 32'd1 || if1.rd_pos !== 5'd1 || if1.rd_i2 !== 2'd1) begin bad++; $display("FAIL guard1_after got=%0h/%0d/%0d exp=1/1/1", if1.rd_data, if1.rd_pos, if1.rd_i2); end
  endtask

  initial begin
    if0.req_valid = 1'b0; if0.req_op = OP_NOP; if0.req_pos = '0; if0.req_guard = 1'b1;
    if0.wr_en = 1'b0; if0.wr_addr = '0; if0.wr_data = '0; if0.rd_ready = 1'b1;
    if1.req_valid = 1'b0; if1.req_op = OP_NOP; if1.req_pos = '0; if1.req_guard = 1'b1;
    if1.wr_en = 1'b0; if1.wr_addr = '0; if1.wr_data = '0; if1.rd_ready = 1'b1;
    test_reset();
    test_inc_dec();
    test_set_coord();
    test_wrap_dec_clamp();
    test_guard_logical();
    test_write_rbw();
    test_nop();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_saturate();
    test_guard_bitwise();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
